// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC engine: default sizes, quadrant
// codes, sequencer states and the arctangent table used by the angle path.
package cordic_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int ITERS_DEF = 16;

    localparam logic [1:0] QUAD_NONE = 2'b00;
    localparam logic [1:0] QUAD_P90  = 2'b01;
    localparam logic [1:0] QUAD_M90  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_ITER,
        ST_DONE
    } state_t;

    // round(atan(2^-i) * 2^15 / pi); other widths rescale the 16-bit entries.
    function automatic int atanTable(input int idx, input int width);
        int base;
        case (idx)
            0:       base = 8192;
            1:       base = 4836;
            2:       base = 2555;
            3:       base = 1297;
            4:       base = 651;
            5:       base = 326;
            6:       base = 163;
            7:       base = 81;
            8:       base = 41;
            9:       base = 20;
            10:      base = 10;
            11:      base = 5;
            12:      base = 3;
            13:      base = 1;
            14:      base = 1;
            default: base = 0;
        endcase
        if (width >= 16) begin
            return base << (width - 16);
        end
        return (base + (1 << (15 - width))) >> (16 - width);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup indexed by the micro-rotation number.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [$clog2(WIDTH)-1:0] i_idx,
    output logic [WIDTH-1:0]         o_atan
);

    always_comb begin
        o_atan = WIDTH'(atanTable(int'(i_idx), WIDTH));
    end

endmodule

// File: rtl/cordic_angle_seq.sv
// Iteration sequencer and residual-angle (Z) path for the iterative CORDIC
// rotation engine: quadrant fold, per-step sign/shift index, done strobe.
module cordic_angle_seq
    import cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITERS = ITERS_DEF
) (
    input  logic                     Clk_i,
    input  logic                     Rst_ni,
    input  logic                     Start_i,
    input  logic [WIDTH-1:0]         Angle_i,
    input  logic                     Abort_i,
    output logic                     Ready_o,
    output logic                     Pre_vld_o,
    output logic [1:0]               Quad_o,
    output logic                     Step_vld_o,
    output logic                     Sign_o,
    output logic [$clog2(WIDTH)-1:0] Iter_o,
    output logic                     Done_o,
    output logic [WIDTH-1:0]         Zres_o
);

    localparam int IW = $clog2(WIDTH);
    localparam logic signed [WIDTH-1:0] QUARTER     = {2'b01, {(WIDTH-2){1'b0}}};
    localparam logic signed [WIDTH-1:0] NEG_QUARTER = {2'b11, {(WIDTH-2){1'b0}}};
    localparam logic [IW-1:0] LAST_ITER = IW'(ITERS - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic signed [WIDTH-1:0]  r_z;
    logic [IW-1:0]            r_iter;
    logic [1:0]               r_quad;
    logic [WIDTH-1:0]         r_zres;

    logic                     w_accept;
    logic signed [WIDTH-1:0]  w_angle;
    logic signed [WIDTH-1:0]  w_fold;
    logic [1:0]               w_quadFold;
    logic [WIDTH-1:0]         w_atan;
    logic                     w_sign;
    logic signed [WIDTH-1:0]  w_znext;

    cordic_atan_rom #(
        .WIDTH (WIDTH)
    ) u_atan_rom (
        .i_idx  (r_iter),
        .o_atan (w_atan)
    );

    assign w_accept = (r_state == ST_IDLE) && Start_i && !Abort_i;
    assign w_angle  = Angle_i;
    assign w_sign   = r_z[WIDTH-1];
    assign w_znext  = w_sign ? (r_z + $signed(w_atan)) : (r_z - $signed(w_atan));

    // Fold the target into [-pi/2, pi/2) so the micro-rotations can converge.
    always_comb begin
        w_fold     = w_angle;
        w_quadFold = QUAD_NONE;
        if (w_angle >= QUARTER) begin
            w_fold     = w_angle - QUARTER;
            w_quadFold = QUAD_P90;
        end else if (w_angle < NEG_QUARTER) begin
            w_fold     = w_angle + QUARTER;
            w_quadFold = QUAD_M90;
        end
    end

    always_comb begin
        w_next     = r_state;
        Ready_o    = 1'b0;
        Pre_vld_o  = 1'b0;
        Quad_o     = QUAD_NONE;
        Step_vld_o = 1'b0;
        Sign_o     = 1'b0;
        Iter_o     = '0;
        Done_o     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                Ready_o = 1'b1;
                if (w_accept) begin
                    w_next = ST_PRE;
                end
            end
            ST_PRE: begin
                Pre_vld_o = 1'b1;
                Quad_o    = r_quad;
                w_next    = Abort_i ? ST_IDLE : ST_ITER;
            end
            ST_ITER: begin
                Step_vld_o = 1'b1;
                Sign_o     = w_sign;
                Iter_o     = r_iter;
                if (Abort_i) begin
                    w_next = ST_IDLE;
                end else if (r_iter == LAST_ITER) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                Done_o = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign Zres_o = r_zres;

    // Residual is captured on the final step so it is already valid while Done_o is high.
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            r_state <= ST_IDLE;
            r_z     <= '0;
            r_iter  <= '0;
            r_quad  <= QUAD_NONE;
            r_zres  <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_z    <= w_fold;
                        r_quad <= w_quadFold;
                    end
                end
                ST_PRE: begin
                    r_iter <= '0;
                end
                ST_ITER: begin
                    if (!Abort_i) begin
                        r_z    <= w_znext;
                        r_iter <= r_iter + IW'(1);
                        if (r_iter == LAST_ITER) begin
                            r_zres <= w_znext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_angle_seq.sv
// Self-checking bench for cordic_angle_seq: directed vector table, random
// angles against an arithmetic reference, and abort/reset/back-to-back sequences.
module tb_cordic_angle_seq;

    localparam int WIDTH = 16;
    localparam int ITERS = 16;

    logic              Clk_i;
    logic              Rst_ni;
    logic              Start_i;
    logic [WIDTH-1:0]  Angle_i;
    logic              Abort_i;
    logic              Ready_o;
    logic              Pre_vld_o;
    logic [1:0]        Quad_o;
    logic              Step_vld_o;
    logic              Sign_o;
    logic [3:0]        Iter_o;
    logic              Done_o;
    logic [WIDTH-1:0]  Zres_o;

    cordic_angle_seq #(
        .WIDTH (WIDTH),
        .ITERS (ITERS)
    ) dut (
        .Clk_i      (Clk_i),
        .Rst_ni     (Rst_ni),
        .Start_i    (Start_i),
        .Angle_i    (Angle_i),
        .Abort_i    (Abort_i),
        .Ready_o    (Ready_o),
        .Pre_vld_o  (Pre_vld_o),
        .Quad_o     (Quad_o),
        .Step_vld_o (Step_vld_o),
        .Sign_o     (Sign_o),
        .Iter_o     (Iter_o),
        .Done_o     (Done_o),
        .Zres_o     (Zres_o)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    typedef struct {
        logic [15:0] angle;
        int          quad;
        logic        s0;
        logic        s1;
    } vec_t;

    int atanRef [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                         41, 20, 10, 5, 3, 1, 1, 0};

    int nChecks = 0;
    int nPass   = 0;

    int          obsPre;
    int          obsQuad;
    logic [15:0] obsSigns;
    int          obsSteps;
    logic        obsIterOk;
    int          obsDone;
    logic [15:0] obsZres;
    int          obsReady;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: fold, then greedy rotate towards zero with the arctan table.
    function automatic void modelOp(input logic [15:0] a, output int q,
                                    output logic [15:0] s, output int zr);
        int z;
        z = int'($signed(a));
        if (z >= 16384) begin
            z = z - 16384;
            q = 1;
        end else if (z < -16384) begin
            z = z + 16384;
            q = 2;
        end else begin
            q = 0;
        end
        s = '0;
        for (int i = 0; i < ITERS; i++) begin
            s[i] = (z < 0);
            z = (z < 0) ? z + atanRef[i] : z - atanRef[i];
        end
        zr = z;
    endfunction

    // Called at a negedge with the DUT idle; cycle k=1 is the cycle after the accept edge.
    task automatic applyStimulus(input logic [15:0] ang, input int abortCycle);
        int readySeen;
        obsPre    = 0;
        obsQuad   = -1;
        obsSigns  = '0;
        obsSteps  = 0;
        obsIterOk = 1'b1;
        obsDone   = 0;
        obsZres   = '0;
        obsReady  = 0;
        readySeen = 0;
        Angle_i = ang;
        Start_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk_i);
            if (k == 1) Start_i = 1'b0;
            Abort_i = (k == abortCycle);
            if (Pre_vld_o) begin
                obsPre  = k;
                obsQuad = int'(Quad_o);
            end
            if (Step_vld_o) begin
                if (obsSteps < 16) obsSigns[obsSteps] = Sign_o;
                if (int'(Iter_o) != obsSteps) obsIterOk = 1'b0;
                obsSteps++;
            end
            if (Done_o) begin
                obsDone = k;
                obsZres = Zres_o;
            end
            if (Ready_o) begin
                obsReady  = k;
                readySeen = 1;
                break;
            end
        end
        Abort_i = 1'b0;
        checkOutput("ready_return", readySeen, 1);
    endtask

    task automatic waitIdle();
        int seen;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk_i);
            if (Ready_o) begin
                seen = 1;
                break;
            end
        end
        checkOutput("idle_wait", seen, 1);
    endtask

    vec_t        vecs [8];
    int          mq;
    logic [15:0] ms;
    int          mz;
    int          prevZres;
    int          absZ;
    logic [15:0] ang;

    initial begin
        vecs[0] = '{16'h0000, 0, 1'b0, 1'b1};
        vecs[1] = '{16'h2000, 0, 1'b0, 1'b0};
        vecs[2] = '{16'h6000, 1, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 2, 1'b1, 1'b1};
        vecs[4] = '{16'hA000, 2, 1'b1, 1'b0};
        vecs[5] = '{16'h4000, 1, 1'b0, 1'b1};
        vecs[6] = '{16'hC000, 0, 1'b1, 1'b1};
        vecs[7] = '{16'h3FFF, 0, 1'b0, 1'b0};

        Rst_ni  = 1'b0;
        Start_i = 1'b0;
        Abort_i = 1'b0;
        Angle_i = '0;
        #1;
        checkOutput("rst_ready", int'(Ready_o), 1);
        checkOutput("rst_pre", int'(Pre_vld_o), 0);
        checkOutput("rst_step", int'(Step_vld_o), 0);
        checkOutput("rst_done", int'(Done_o), 0);
        checkOutput("rst_zres", int'(Zres_o), 0);
        repeat (2) @(negedge Clk_i);
        Rst_ni = 1'b1;
        @(negedge Clk_i);

        for (int v = 0; v < 8; v++) begin
            modelOp(vecs[v].angle, mq, ms, mz);
            applyStimulus(vecs[v].angle, -1);
            checkOutput("vec_pre_cycle", obsPre, 1);
            checkOutput("vec_quad", obsQuad, vecs[v].quad);
            checkOutput("vec_sign0", int'(obsSigns[0]), int'(vecs[v].s0));
            checkOutput("vec_sign1", int'(obsSigns[1]), int'(vecs[v].s1));
            checkOutput("vec_steps", obsSteps, ITERS);
            checkOutput("vec_iter_seq", int'(obsIterOk), 1);
            checkOutput("vec_signs", int'(obsSigns), int'(ms));
            checkOutput("vec_done_cycle", obsDone, ITERS + 2);
            checkOutput("vec_ready_cycle", obsReady, ITERS + 3);
            checkOutput("vec_zres", int'($signed(obsZres)), mz);
            absZ = int'($signed(obsZres));
            if (absZ < 0) absZ = -absZ;
            checkOutput("vec_zres_bound", int'(absZ <= 8), 1);
            prevZres = mz;
        end

        for (int r = 0; r < 20; r++) begin
            ang = 16'($urandom_range(0, 65535));
            modelOp(ang, mq, ms, mz);
            applyStimulus(ang, -1);
            checkOutput("rnd_quad", obsQuad, mq);
            checkOutput("rnd_signs", int'(obsSigns), int'(ms));
            checkOutput("rnd_done_cycle", obsDone, ITERS + 2);
            checkOutput("rnd_zres", int'($signed(obsZres)), mz);
            absZ = int'($signed(obsZres));
            if (absZ < 0) absZ = -absZ;
            checkOutput("rnd_zres_bound", int'(absZ <= 8), 1);
            prevZres = mz;
        end

        begin : backToBack
            int readyAt [$];
            int overlap;
            overlap = 0;
            Angle_i = 16'h1234;
            for (int c = 0; c < 57; c++) begin
                if (Ready_o) readyAt.push_back(c);
                if (Ready_o && Done_o) overlap++;
                if (c == 0) Start_i = 1'b1;
                @(negedge Clk_i);
            end
            Start_i = 1'b0;
            checkOutput("b2b_accepts", readyAt.size(), 3);
            if (readyAt.size() == 3) begin
                checkOutput("b2b_first", readyAt[0], 0);
                checkOutput("b2b_gap1", readyAt[1] - readyAt[0], ITERS + 3);
                checkOutput("b2b_gap2", readyAt[2] - readyAt[1], ITERS + 3);
            end
            checkOutput("b2b_done_ready_overlap", overlap, 0);
            modelOp(16'h1234, mq, ms, mz);
            waitIdle();
            checkOutput("b2b_zres", int'($signed(Zres_o)), mz);
            prevZres = mz;
        end

        begin : abortSeq
            int doneSeen;
            applyStimulus(16'h1500, 6);
            checkOutput("abort_ready_cycle", obsReady, 7);
            checkOutput("abort_steps", obsSteps, 5);
            checkOutput("abort_no_done", obsDone, 0);
            checkOutput("abort_zres_kept", int'($signed(Zres_o)), prevZres);
            doneSeen = 0;
            repeat (5) begin
                @(negedge Clk_i);
                if (Done_o) doneSeen++;
            end
            checkOutput("abort_no_late_done", doneSeen, 0);
            Start_i = 1'b1;
            Abort_i = 1'b1;
            Angle_i = 16'h0100;
            @(negedge Clk_i);
            Start_i = 1'b0;
            Abort_i = 1'b0;
            checkOutput("start_abort_ready", int'(Ready_o), 1);
            checkOutput("start_abort_pre", int'(Pre_vld_o), 0);
            @(negedge Clk_i);
            checkOutput("start_abort_pre2", int'(Pre_vld_o | Step_vld_o), 0);
        end

        Angle_i = 16'h0F00;
        Start_i = 1'b1;
        @(negedge Clk_i);
        Start_i = 1'b0;
        repeat (4) @(negedge Clk_i);
        checkOutput("mid_iter_step", int'(Step_vld_o), 1);
        #2;
        Rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_ready", int'(Ready_o), 1);
        checkOutput("async_rst_step", int'(Step_vld_o), 0);
        checkOutput("async_rst_sign_iter", int'({Sign_o, Iter_o}), 0);
        checkOutput("async_rst_zres", int'(Zres_o), 0);
        @(negedge Clk_i);
        Rst_ni = 1'b1;
        @(negedge Clk_i);
        modelOp(16'hD800, mq, ms, mz);
        applyStimulus(16'hD800, -1);
        checkOutput("post_rst_quad", obsQuad, mq);
        checkOutput("post_rst_done_cycle", obsDone, ITERS + 2);
        checkOutput("post_rst_zres", int'($signed(obsZres)), mz);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/cordic_angle_seq.md
Name: cordic_angle_seq

Overview:
- Iteration sequencer and angle (Z) path for the iterative CORDIC rotation engine.
- Sits directly upstream of the X/Y rotation stage. Per iteration it drives that stage's sign input and the shift index, and it tracks the residual angle using an arctan table.
- Accepts one target angle per operation through a valid/ready handshake. Emits a quadrant pre-rotation code, then one sign per iteration, then a done pulse carrying the residual angle.

Parameters:
- WIDTH, 16, angle and data width; binary angle format, 0x8000 = -pi, 0x4000 = +pi/2.
- ITERS, 16, number of micro-rotations; legal range 1..WIDTH.

Ports:
- Clk_i  in  1  clock, rising edge.
- Rst_ni  in  1  asynchronous active-low reset.
- Start_i  in  1  request valid; accepted when Start_i && Ready_o.
- Angle_i  in  WIDTH  signed target angle, sampled on accept.
- Abort_i  in  1  synchronous abort of the current operation.
- Ready_o  out  1  high only in IDLE.
- Pre_vld_o  out  1  one-cycle strobe; Quad_o is valid.
- Quad_o  out  2  00 none, 01 pre-rotate +90deg, 10 pre-rotate -90deg.
- Step_vld_o  out  1  high while iterating; Sign_o and Iter_o are valid.
- Sign_o  out  1  1 = rotate clockwise (Z negative); feeds the rotation stage's sign input.
- Iter_o  out  $clog2(WIDTH)  current shift index i.
- Done_o  out  1  one-cycle completion strobe.
- Zres_o  out  WIDTH  residual angle after the last iteration; held until the next accept.

Behaviour:
- Reset (Rst_ni low, asynchronous):
  - State goes to IDLE.
  - Ready_o=1; all other outputs 0, including Z and the iteration counter.
- States: IDLE, PRE, ITER, DONE.
- IDLE:
  - Ready_o=1.
  - Start_i=1 and Abort_i=0: latch the folded angle into Z, then go to PRE.
  - Start_i=1 and Abort_i=1 together: Abort_i wins; nothing is accepted and the state stays IDLE.
- Fold on accept, with A = Angle_i signed:
  - A >= 0x4000: Z = A - 0x4000, Quad = 01.
  - A < -0x4000 (includes 0x8000): Z = A + 0x4000, Quad = 10.
  - Otherwise: Z = A, Quad = 00.
  - Folded Z always lies in [-0x4000, 0x3FFF].
- PRE:
  - Lasts one cycle; Pre_vld_o=1 and Quad_o is driven.
  - Counter i = 0; next state ITER.
- ITER:
  - Lasts ITERS cycles; Step_vld_o=1, Iter_o=i, Sign_o=Z[WIDTH-1], all combinational from registered Z and i.
  - Each edge: if Sign_o, Z <= Z + atan[i], else Z <= Z - atan[i]; then i <= i+1.
  - Add/subtract is WIDTH-bit two's complement. Folded range guarantees no overflow.
  - After the step with i = ITERS-1, go to DONE.
- DONE:
  - Lasts one cycle; Done_o=1 and Zres_o=Z (registered copy). Next state IDLE.
- Latency, with accept at edge 0:
  - Pre_vld_o high in cycle 1.
  - Steps run in cycles 2..ITERS+1.
  - Done_o high in cycle ITERS+2.
  - Ready_o high again in cycle ITERS+3.
  - Throughput is one operation per ITERS+3 cycles.
- Abort_i=1 in PRE, ITER or DONE:
  - Next state is IDLE.
  - No Done_o; Zres_o keeps its previous value; no further strobes.
- Start_i is ignored outside IDLE and is not queued.
- atan table: round(atan(2^-i) * 2^(WIDTH-1) / pi). For WIDTH=16, i = 0..15:
  - 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- Accuracy: with ITERS=16, |Zres_o| <= 8 LSB for any input.
- Downstream contract: the rotation stage applies Quad_o on Pre_vld_o, then uses one Sign_o/Iter_o pair per Step_vld_o cycle.

Decomposition:
- cordic_pkg holds:
  - WIDTH/ITERS defaults.
  - Quad code constants (QUAD_NONE, QUAD_P90, QUAD_M90).
  - State enum.
  - Constant atan function or table generator.
- One sub-module: cordic_atan_rom.
  - Combinational; index in, WIDTH-bit atan out.
  - Parameterised by WIDTH.
  - Shared later by vectoring mode.

Test Plan:
1. Angle_i=0x0000 -> Quad 00; Sign_o sequence starts 0,1 (Z: 0 -> -8192 -> -3356); Done_o in cycle 18; |Zres_o|<=8.
2. Angle_i=0x2000 (45deg) -> Quad 00; iter0 Sign 0 (Z -> 0); iter1 Sign 0 (Z -> -4836); iter2 Sign 1; |Zres_o|<=8.
3. Angle_i=0x6000 (135deg) -> Quad 01, Z0=0x2000, signs identical to test 2. Angle_i=0x8000 -> Quad 10, Z0=0xC000, iter0 Sign 1.
4. Start_i held high continuously -> accepts exactly every 19 cycles; Ready_o low cycles 1..18 after each accept; no accept in DONE.
5. Abort_i pulsed in the 5th ITER cycle -> IDLE next cycle, Ready_o=1, no Done_o, Zres_o unchanged. Start+Abort together in IDLE -> no accept.
6. Rst_ni dropped asynchronously mid-ITER (between edges) -> outputs clear immediately to reset values; after release, a new Start runs normally.
